// File: rtl/sm_clk_ctrl_if.sv
// Handshake bundle between the board-side debug controls and the CPU clock controller.
// The master drives the controls and current PC; the slave (controller) returns the CPU enable and status.
interface sm_clk_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic [1:0]       mode;
  logic [3:0]       devide;
  logic             stepBtn;
  logic             burstGo;
  logic [15:0]      burstLen;
  logic             bpEnable;
  logic [PC_W-1:0]  bpAddr;
  logic [PC_W-1:0]  pc;
  logic             cpuEn;
  logic             busy;
  logic             halted;
  logic             bpHit;
  logic [CNT_W-1:0] tickCount;

  modport master (
    output mode, devide, stepBtn, burstGo, burstLen, bpEnable, bpAddr, pc,
    input  cpuEn, busy, halted, bpHit, tickCount
  );

  modport slave (
    input  mode, devide, stepBtn, burstGo, burstLen, bpEnable, bpAddr, pc,
    output cpuEn, busy, halted, bpHit, tickCount
  );
endinterface

// File: rtl/sm_clk_ctrl.sv
// Debug clock controller: issues single-cycle CPU advance pulses in halt/free-run/step/burst
// modes, with an optional PC breakpoint that stops free-run and burst before the matching PC.
module sm_clk_ctrl #(
  parameter int SHIFT = 16,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst,
  sm_clk_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_HALT, S_FREE, S_BURST, S_BREAK} state_t;

  // Wide enough for the largest period exponent, SHIFT + 15.
  localparam int PRE_W = SHIFT + 16;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic [PRE_W-1:0] pre_limit;
  logic [15:0]      remaining;
  logic             step_q;
  logic             first_tick;
  logic [1:0]       mode_q;
  logic [3:0]       devide_q;
  logic             tick;
  logic             rate_chg;
  logic             bp_match;
  logic             step_edge;
  logic             leave_run;

  always_comb begin
    pre_limit = (PRE_W'(1) << (SHIFT + 32'(bus.devide))) - PRE_W'(1);
    tick      = (prescaler == pre_limit);
    rate_chg  = (bus.mode != mode_q) || (bus.devide != devide_q);
    bp_match  = bus.bpEnable && (bus.pc == bus.bpAddr) && !first_tick;
    step_edge = bus.stepBtn && !step_q;
    leave_run = ((state == S_FREE) && (bus.mode != 2'b01)) ||
                ((state == S_BURST) && (bus.mode != 2'b11));
  end

  // Status bits in {busy, halted, bpHit} order, always loaded alongside the state they decode.
  function automatic logic [2:0] flags(state_t s);
    return {(s == S_FREE) || (s == S_BURST), s == S_HALT, s == S_BREAK};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state                               <= S_HALT;
      prescaler                           <= '0;
      remaining                           <= '0;
      step_q                              <= 1'b0;
      first_tick                          <= 1'b0;
      mode_q                              <= '0;
      devide_q                            <= '0;
      bus.cpuEn                           <= 1'b0;
      bus.tickCount                       <= '0;
      {bus.busy, bus.halted, bus.bpHit}   <= flags(S_HALT);
    end else begin
      step_q    <= bus.stepBtn;
      mode_q    <= bus.mode;
      devide_q  <= bus.devide;
      bus.cpuEn <= 1'b0;

      case (state)
        S_HALT: begin
          prescaler <= '0;
          if (bus.mode == 2'b01) begin
            state                             <= S_FREE;
            {bus.busy, bus.halted, bus.bpHit} <= flags(S_FREE);
            first_tick                        <= 1'b1;
          end else if (bus.mode == 2'b11 && bus.burstGo && bus.burstLen != 16'd0) begin
            state                             <= S_BURST;
            {bus.busy, bus.halted, bus.bpHit} <= flags(S_BURST);
            remaining                         <= bus.burstLen;
            first_tick                        <= 1'b1;
          end else if (bus.mode == 2'b10 && step_edge) begin
            bus.cpuEn     <= 1'b1;
            bus.tickCount <= bus.tickCount + CNT_W'(1);
          end
        end

        S_FREE, S_BURST: begin
          // A mode change beats a coincident tick; a rate change restarts the period.
          if (leave_run) begin
            state                             <= S_HALT;
            {bus.busy, bus.halted, bus.bpHit} <= flags(S_HALT);
            prescaler                         <= '0;
          end else if (rate_chg) begin
            prescaler <= '0;
          end else if (tick) begin
            prescaler <= '0;
            if (bp_match) begin
              state                             <= S_BREAK;
              {bus.busy, bus.halted, bus.bpHit} <= flags(S_BREAK);
            end else begin
              bus.cpuEn     <= 1'b1;
              bus.tickCount <= bus.tickCount + CNT_W'(1);
              first_tick    <= 1'b0;
              if (state == S_BURST) begin
                remaining <= remaining - 16'd1;
                if (remaining == 16'd1) begin
                  state                             <= S_HALT;
                  {bus.busy, bus.halted, bus.bpHit} <= flags(S_HALT);
                end
              end
            end
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end

        S_BREAK: begin
          prescaler <= '0;
          if (bus.mode == 2'b00) begin
            state                             <= S_HALT;
            {bus.busy, bus.halted, bus.bpHit} <= flags(S_HALT);
          end
        end

        default: begin
          state                             <= S_HALT;
          {bus.busy, bus.halted, bus.bpHit} <= flags(S_HALT);
          prescaler                         <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Directed bench for sm_clk_ctrl with SHIFT=1, devide=1 (free-run period of 4 clocks).
// Each step drives inputs just after a rising edge and checks outputs 1 time unit later.
module tb_sm_clk_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_clk_ctrl_if #(.PC_W(32), .CNT_W(32)) bus();

  sm_clk_ctrl #(.SHIFT(1), .PC_W(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total       = 0;
  int passed      = 0;
  int cyc         = 0;
  int last_pulse  = -1;
  int exp_gap     = 0;
  int gap_err     = 0;
  int consec_err  = 0;
  int model_ticks = 0;
  int p;
  bit prev_en     = 1'b0;
  bit track_pc    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-18s got %0h expected %0h", tag, obs, exp);
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_phase(input int gap);
    exp_gap    = gap;
    last_pulse = -1;
  endtask

  // Advance n clocks, counting CPU pulses and checking their spacing; pc follows the CPU if tracked.
  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cpuEn === 1'b1) begin
        pulses++;
        model_ticks++;
        if (prev_en) consec_err++;
        if (last_pulse >= 0 && exp_gap != 0 && (cyc - last_pulse) != exp_gap) gap_err++;
        last_pulse = cyc;
        if (track_pc) bus.pc = bus.pc + 32'd4;
      end
      prev_en = (bus.cpuEn === 1'b1);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.mode     = 2'b00;
    bus.devide   = 4'd1;
    bus.stepBtn  = 1'b0;
    bus.burstGo  = 1'b0;
    bus.burstLen = 16'd0;
    bus.bpEnable = 1'b0;
    bus.bpAddr   = 32'h0;
    bus.pc       = 32'h0;

    // Reset state
    run(2, p);
    chk("rst_halted", 64'(bus.halted), 64'd1);
    chk("rst_cpu_en", 64'(bus.cpuEn), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_bp_hit", 64'(bus.bpHit), 64'd0);
    chk("rst_tick_count", 64'(bus.tickCount), 64'd0);
    rst = 1'b0;
    model_ticks = 0;

    // Free run: pulses on edges 4, 8, ..., 40 after entry
    start_phase(4);
    bus.mode = 2'b01;
    run(41, p);
    chk("free_pulses", 64'(p), 64'd10);
    chk("free_busy", 64'(bus.busy), 64'd1);
    chk("free_tick_count", 64'(bus.tickCount), 64'(model_ticks));
    bus.mode = 2'b00;
    run(1, p);
    chk("free_stop_halted", 64'(bus.halted), 64'd1);
    run(10, p);
    chk("halt_no_pulses", 64'(p), 64'd0);

    // Single step: held button yields one pulse per rising edge, one cycle after the sample
    start_phase(0);
    bus.mode    = 2'b10;
    bus.stepBtn = 1'b1;
    run(1, p);
    chk("step1_latency", 64'(bus.cpuEn), 64'd1);
    run(9, p);
    chk("step1_hold", 64'(p), 64'd0);
    bus.stepBtn = 1'b0;
    run(2, p);
    bus.stepBtn = 1'b1;
    run(1, p);
    chk("step2_latency", 64'(bus.cpuEn), 64'd1);
    run(3, p);
    bus.stepBtn = 1'b0;
    run(1, p);
    bus.mode = 2'b00;
    p = 0;
    for (int k = 0; k < 4; k++) begin
      int q;
      bus.stepBtn = ~bus.stepBtn;
      run(1, q);
      p += q;
    end
    chk("step_in_halt_mode", 64'(p), 64'd0);
    chk("step_tick_count", 64'(bus.tickCount), 64'(model_ticks));

    // Burst of 5
    start_phase(4);
    bus.stepBtn  = 1'b0;
    bus.mode     = 2'b11;
    bus.burstLen = 16'd5;
    bus.burstGo  = 1'b1;
    run(1, p);
    bus.burstGo = 1'b0;
    chk("burst_busy", 64'(bus.busy), 64'd1);
    run(3, p);
    chk("burst_first_wait", 64'(p), 64'd0);
    run(1, p);
    chk("burst_first_pulse", 64'(bus.cpuEn), 64'd1);
    run(26, p);
    chk("burst_rest", 64'(p), 64'd4);
    chk("burst_done_halted", 64'(bus.halted), 64'd1);
    bus.burstLen = 16'd0;
    bus.burstGo  = 1'b1;
    run(1, p);
    bus.burstGo = 1'b0;
    chk("burst_len0_halted", 64'(bus.halted), 64'd1);
    run(10, p);
    chk("burst_len0_pulses", 64'(p), 64'd0);

    // Breakpoint at 0x0C with pc tracking the CPU
    bus.mode = 2'b00;
    run(1, p);
    start_phase(4);
    bus.pc       = 32'h0;
    bus.bpAddr   = 32'h0C;
    bus.bpEnable = 1'b1;
    track_pc     = 1'b1;
    bus.mode     = 2'b01;
    run(30, p);
    chk("bp_pulses", 64'(p), 64'd3);
    chk("bp_hit", 64'(bus.bpHit), 64'd1);
    chk("bp_not_busy", 64'(bus.busy), 64'd0);
    chk("bp_pc", 64'(bus.pc), 64'h0C);
    bus.mode = 2'b00;
    run(1, p);
    chk("bp_clear_halted", 64'(bus.halted), 64'd1);
    chk("bp_clear_hit", 64'(bus.bpHit), 64'd0);
    start_phase(4);
    bus.mode = 2'b01;
    run(5, p);
    chk("bp_first_tick", 64'(p), 64'd1);
    run(4, p);
    chk("bp_after_leave", 64'(p), 64'd1);
    chk("bp_pc_after", 64'(bus.pc), 64'h14);
    bus.mode     = 2'b00;
    track_pc     = 1'b0;
    bus.bpEnable = 1'b0;
    run(2, p);

    // Burst abort into free-run, then rate change mid-period
    start_phase(0);
    bus.mode     = 2'b11;
    bus.burstLen = 16'd100;
    bus.burstGo  = 1'b1;
    run(1, p);
    bus.burstGo = 1'b0;
    run(12, p);
    chk("abort_pre_pulses", 64'(p), 64'd3);
    bus.mode = 2'b01;
    run(1, p);
    chk("abort_halted", 64'(bus.halted), 64'd1);
    chk("abort_no_pulse", 64'(bus.cpuEn), 64'd0);
    run(1, p);
    chk("abort_to_free", 64'(bus.busy), 64'd1);
    run(4, p);
    chk("abort_free_pulse", 64'(bus.cpuEn), 64'd1);
    run(2, p);
    bus.devide = 4'd2;
    run(8, p);
    chk("rate_restart_wait", 64'(p), 64'd0);
    run(1, p);
    chk("rate_restart_pulse", 64'(bus.cpuEn), 64'd1);
    chk("pre_reset_ticks", 64'(bus.tickCount), 64'(model_ticks));

    // Reset in the middle of a burst
    bus.mode   = 2'b00;
    bus.devide = 4'd1;
    run(1, p);
    bus.mode     = 2'b11;
    bus.burstLen = 16'd10;
    bus.burstGo  = 1'b1;
    run(1, p);
    bus.burstGo = 1'b0;
    run(6, p);
    chk("midburst_pulse", 64'(p), 64'd1);
    rst = 1'b1;
    model_ticks = 0;
    run(1, p);
    chk("midrst_halted", 64'(bus.halted), 64'd1);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_cpu_en", 64'(bus.cpuEn), 64'd0);
    chk("midrst_tick_count", 64'(bus.tickCount), 64'd0);
    rst      = 1'b0;
    bus.mode = 2'b00;
    run(10, p);
    chk("post_rst_pulses", 64'(p), 64'd0);

    chk("pulse_gap_errors", 64'(gap_err), 64'd0);
    chk("back_to_back", 64'(consec_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
